// File: rtl/fib2fmac_txctrl.sv
// TX bridge from the host write FIFOs (data + byte count) into the FMAC TX FIFOs.
// Data words are forwarded first; the byte count goes last because FMAC transmits on its arrival.
module fib2fmac_txctrl #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned BCNT_WIDTH    = 32,
  parameter int unsigned MAX_PKT_BYTES = 9600
) (
  input  logic                  clk_fib,
  input  logic                  reset_,
  output logic                  rden_wf,
  output logic                  rden_wcf,
  input  logic [DATA_WIDTH-1:0] dataout_wf,
  input  logic [BCNT_WIDTH-1:0] dataout_wcf,
  input  logic                  rdempty_wf,
  input  logic                  rdempty_wcf,
  input  logic                  fib_tx_mac_data_full,
  input  logic                  fib_tx_mac_bcnt_full,
  output logic                  fib_tx_mac_wr,
  output logic [DATA_WIDTH-1:0] fib_tx_mac_data,
  output logic                  fib_tx_mac_eop,
  output logic                  fib_tx_mac_bcnt_wr,
  output logic [15:0]           fib_tx_mac_bcnt,
  output logic                  err_len,
  output logic                  test
);

  localparam int unsigned WCNT_W   = 14;
  localparam logic [15:0] MAX_BCNT = 16'(MAX_PKT_BYTES);

  typedef enum logic [4:0] {
    TX_IDLE  = 5'b00001,
    TX_RDCNT = 5'b00010,
    TX_LATCH = 5'b00100,
    TX_XFER  = 5'b01000,
    TX_DONE  = 5'b10000
  } tx_state_t;

  tx_state_t          state, state_nxt;
  logic [15:0]        bcnt_q;
  logic [WCNT_W-1:0]  req_left, rcv_left;
  logic               drop;
  logic               rd_d1;
  logic               bcnt_wr_nxt;

  logic [15:0]        cnt_in;
  logic [16:0]        cnt_sum;
  logic [WCNT_W-1:0]  words_in;
  logic               drop_in;
  logic               unused_bcnt_hi;

  // 17-bit sum so counts near 0xFFFF still round up instead of wrapping to 0 words
  assign cnt_in         = dataout_wcf[15:0];
  assign cnt_sum        = {1'b0, cnt_in} + 17'd7;
  assign words_in       = cnt_sum[16:3];
  assign drop_in        = (cnt_in == '0) || (cnt_in > MAX_BCNT);
  assign unused_bcnt_hi = ^dataout_wcf[BCNT_WIDTH-1:16];
  assign test           = 1'b0;

  always_ff @(posedge clk_fib or negedge reset_) begin
    if (!reset_) state <= TX_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rden_wcf    = 1'b0;
    rden_wf     = 1'b0;
    err_len     = 1'b0;
    bcnt_wr_nxt = 1'b0;
    case (state)
      TX_IDLE:  if (!rdempty_wcf) state_nxt = TX_RDCNT;
      TX_RDCNT: begin
        rden_wcf  = 1'b1;
        state_nxt = TX_LATCH;
      end
      TX_LATCH: begin
        err_len   = drop_in;
        state_nxt = (cnt_in == '0) ? TX_IDLE : TX_XFER;
      end
      TX_XFER: begin
        // dropped packets ignore FMAC backpressure; they are only drained
        rden_wf = (req_left != '0) && !rdempty_wf && (drop || !fib_tx_mac_data_full);
        if (rcv_left == '0) state_nxt = drop ? TX_IDLE : TX_DONE;
      end
      TX_DONE: begin
        if (!fib_tx_mac_bcnt_full) begin
          bcnt_wr_nxt = 1'b1;
          state_nxt   = TX_IDLE;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_fib or negedge reset_) begin
    if (!reset_) begin
      bcnt_q             <= '0;
      req_left           <= '0;
      rcv_left           <= '0;
      drop               <= 1'b0;
      rd_d1              <= 1'b0;
      fib_tx_mac_wr      <= 1'b0;
      fib_tx_mac_data    <= '0;
      fib_tx_mac_eop     <= 1'b0;
      fib_tx_mac_bcnt_wr <= 1'b0;
      fib_tx_mac_bcnt    <= '0;
    end else begin
      rd_d1              <= rden_wf;
      fib_tx_mac_wr      <= 1'b0;
      fib_tx_mac_eop     <= 1'b0;
      fib_tx_mac_bcnt_wr <= bcnt_wr_nxt;
      if (state == TX_LATCH) begin
        bcnt_q   <= cnt_in;
        req_left <= words_in;
        rcv_left <= words_in;
        drop     <= drop_in;
      end
      if (rden_wf) req_left <= req_left - 1'b1;
      if (rd_d1) begin
        rcv_left       <= rcv_left - 1'b1;
        fib_tx_mac_wr  <= !drop;
        fib_tx_mac_eop <= (rcv_left == WCNT_W'(1)) && !drop;
        if (!drop) fib_tx_mac_data <= dataout_wf;
      end
      if (bcnt_wr_nxt) fib_tx_mac_bcnt <= bcnt_q;
    end
  end

endmodule
